// File: rtl/arith_pkg.sv
// Shared constants for the arithmetic lab blocks: FSM state encodings for
// the serial datapaths and the default operand width.
package arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with bout set when the bit
// position has to borrow from the next higher position.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing diff = a - b over WIDTH bits, one bit per
// clock, LSB first, with a registered borrow between bit positions. A
// start/busy/done handshake lets a controller chain operations back to back:
// a new start may be accepted in the DONE cycle without passing through IDLE.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] diff_q;
    logic             borrow;
    logic             borrow_out_q;
    logic [CW-1:0]    count;

    logic             bit_d;
    logic             bit_borrow;

    // The single bit slice works on the current LSBs of the operand shifters.
    full_subtractor u_bit_slice (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .bin  (borrow),
        .d    (bit_d),
        .bout (bit_borrow)
    );

    // Sequencer and datapath: capture operands on an accepted start, then
    // retire one result bit per clock into the top of the diff shifter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            sh_a         <= '0;
            sh_b         <= '0;
            diff_q       <= '0;
            borrow       <= 1'b0;
            borrow_out_q <= 1'b0;
            count        <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        sh_a         <= a;
                        sh_b         <= b;
                        diff_q       <= '0;
                        borrow       <= 1'b0;
                        borrow_out_q <= 1'b0;
                        count        <= '0;
                        state        <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    diff_q <= {bit_d, diff_q[WIDTH-1:1]};
                    sh_a   <= {1'b0, sh_a[WIDTH-1:1]};
                    sh_b   <= {1'b0, sh_b[WIDTH-1:1]};
                    borrow <= bit_borrow;
                    count  <= count + 1'b1;
                    if (count == LAST_BIT) begin
                        borrow_out_q <= bit_borrow;
                        state        <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign busy       = (state == ST_RUN);
    assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor. Expected results come from plain
// integer arithmetic on the operands; timing expectations come from the
// handshake rules (WIDTH run edges after the accepting edge, one-cycle done).
module tb_serial_subtractor;

    localparam int W = 8;
    localparam int MODV = 1 << W;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         busy;
    logic         done;

    int tests_run;
    int tests_failed;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .diff       (diff),
        .borrow_out (borrow_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: unsigned subtraction modulo 2^W and an a<b borrow.
    function automatic logic [W-1:0] model_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        r = int'(x) - int'(y);
        if (r < 0) r = r + MODV;
        return W'(r);
    endfunction

    function automatic logic model_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
        return int'(x) < int'(y);
    endfunction

    // Issue one operation from a point #1 after a rising edge; returns the
    // result seen in the done cycle, the edges from accept to done, and the
    // number of sampled cycles with busy high.
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          output logic [W-1:0] r_diff, output logic r_borrow,
                          output int edges, output int busy_cycles, output logic timed_out);
        a = op_a;
        b = op_b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0;
        busy_cycles = busy ? 1 : 0;
        timed_out = 1'b1;
        r_diff = '0;
        r_borrow = 1'b0;
        for (int i = 0; i < 4 * W; i++) begin
            @(posedge clk); #1;
            edges++;
            if (done) begin
                r_diff = diff;
                r_borrow = borrow_out;
                timed_out = 1'b0;
                break;
            end
            if (busy) busy_cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        #7;
        tests_run++;
        if ({diff, borrow_out, busy, done} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got diff=%0d borrow=%0b busy=%0b done=%0b, want all 0",
                     diff, borrow_out, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_no_start: got busy=%0b done=%0b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] rd;
        logic rb, to;
        int edges, bc;
        run_op(8'd5, 8'd3, rd, rb, edges, bc, to);
        tests_run++;
        if (to || edges != W) begin
            tests_failed++;
            $display("[TB] FAIL basic_latency: got %0d edges (timeout=%0b), want %0d", edges, to, W);
        end
        tests_run++;
        if (rd !== 8'd2 || rb !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_result: got diff=%0d borrow=%0b, want 2 0", rd, rb);
        end
        tests_run++;
        if (bc != W) begin
            tests_failed++;
            $display("[TB] FAIL basic_busy_cycles: got %0d, want %0d", bc, W);
        end
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b0 || diff !== 8'd2 || borrow_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_hold: got done=%0b diff=%0d borrow=%0b, want 0 2 0", done, diff, borrow_out);
        end
    endtask

    task automatic test_table();
        logic [W-1:0] ta [5];
        logic [W-1:0] tb [5];
        logic [W-1:0] rd;
        logic rb, to;
        int edges, bc;
        ta = '{8'd3, 8'd0, 8'd255, 8'd0, 8'd128};
        tb = '{8'd5, 8'd1, 8'd255, 8'd0, 8'd1};
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], rd, rb, edges, bc, to);
            tests_run++;
            if (to || rd !== model_diff(ta[i], tb[i]) || rb !== model_borrow(ta[i], tb[i])) begin
                tests_failed++;
                $display("[TB] FAIL table_%0d (%0d-%0d): got diff=%0d borrow=%0b timeout=%0b, want %0d %0b",
                         i, ta[i], tb[i], rd, rb, to, model_diff(ta[i], tb[i]), model_borrow(ta[i], tb[i]));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_start_during_run();
        int pulses, first_edge;
        logic [W-1:0] rd;
        logic rb;
        a = 8'd77;
        b = 8'd33;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0;
        first_edge = -1;
        rd = '0;
        rb = 1'b0;
        for (int i = 1; i <= 3 * W; i++) begin
            if (i == 4) begin
                a = 8'd200;
                b = 8'd10;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                if (first_edge < 0) begin
                    first_edge = i;
                    rd = diff;
                    rb = borrow_out;
                end
            end
        end
        tests_run++;
        if (pulses != 1 || first_edge != W) begin
            tests_failed++;
            $display("[TB] FAIL midrun_start_timing: got %0d done pulses, first at edge %0d, want 1 at %0d",
                     pulses, first_edge, W);
        end
        tests_run++;
        if (rd !== model_diff(8'd77, 8'd33) || rb !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrun_start_result: got diff=%0d borrow=%0b, want %0d 0", rd, rb, model_diff(8'd77, 8'd33));
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] rd;
        logic rb, to;
        int edges, bc, gap;
        run_op(8'd9, 8'd20, rd, rb, edges, bc, to);
        tests_run++;
        if (to || rd !== model_diff(8'd9, 8'd20) || rb !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first: got diff=%0d borrow=%0b, want %0d 1", rd, rb, model_diff(8'd9, 8'd20));
        end
        a = 8'd10;
        b = 8'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || diff !== '0 || borrow_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_accept_in_done: got busy=%0b diff=%0d borrow=%0b, want 1 0 0", busy, diff, borrow_out);
        end
        gap = 1;
        to = 1'b1;
        for (int i = 0; i < 4 * W; i++) begin
            @(posedge clk); #1;
            gap++;
            if (done) begin
                to = 1'b0;
                break;
            end
        end
        tests_run++;
        if (to || gap != W + 1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_period: got %0d cycles between done pulses (timeout=%0b), want %0d", gap, to, W + 1);
        end
        tests_run++;
        if (diff !== 8'd6 || borrow_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second: got diff=%0d borrow=%0b, want 6 0", diff, borrow_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        logic [W-1:0] rd;
        logic rb, to;
        int edges, bc, pulses;
        a = 8'd200;
        b = 8'd100;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({diff, borrow_out, busy, done} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_immediate: got diff=%0d borrow=%0b busy=%0b done=%0b, want all 0",
                     diff, borrow_out, busy, done);
        end
        pulses = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2 * W) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        tests_run++;
        if (pulses != 0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_no_done: got %0d done pulses, want 0", pulses);
        end
        run_op(8'd200, 8'd100, rd, rb, edges, bc, to);
        tests_run++;
        if (to || rd !== 8'd100 || rb !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_rerun: got diff=%0d borrow=%0b timeout=%0b, want 100 0", rd, rb, to);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rbv, rd;
        logic rb, to;
        int edges, bc;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom_range(0, MODV - 1));
            rbv = W'($urandom_range(0, MODV - 1));
            run_op(ra, rbv, rd, rb, edges, bc, to);
            tests_run++;
            if (to || edges != W || rd !== model_diff(ra, rbv) || rb !== model_borrow(ra, rbv)) begin
                tests_failed++;
                $display("[TB] FAIL random_%0d (%0d-%0d): got diff=%0d borrow=%0b edges=%0d, want %0d %0b %0d",
                         i, ra, rbv, rd, rb, edges, model_diff(ra, rbv), model_borrow(ra, rbv), W);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_table();
        test_start_during_run();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial subtractor. It computes diff = a - b over WIDTH bits, one bit per clock, LSB first, using a registered borrow. It is the inverse-direction companion to the combinational half/full-adder blocks in the arithmetic lab set. It uses a start/busy/done handshake so a controller or testbench can issue back-to-back operations.

Parameters:
WIDTH, 8, operand and result width in bits (minimum 2)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when accepted (see Behaviour)
a  input  WIDTH  minuend; captured on the accepted start edge
b  input  WIDTH  subtrahend; captured on the accepted start edge
diff  output  WIDTH  result a - b modulo 2^WIDTH
borrow_out  output  1  1 when a < b (unsigned)
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when diff/borrow_out become valid

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high.
- Reset values: state=IDLE, diff=0, borrow_out=0, busy=0, done=0, internal borrow=0, bit counter=0, operand shift registers=0.
- FSM states and transitions:
  - IDLE: busy=0, done=0. If start=1, capture a into sh_a and b into sh_b, clear borrow and count, clear the diff shift register, then go to RUN.
  - RUN: busy=1, done=0. Each cycle:
    - d = sh_a[0] ^ sh_b[0] ^ borrow
    - nb = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & borrow)
    - shift d into the diff register from the MSB side, shifting right
    - shift sh_a and sh_b right by one; borrow <= nb; count++
    - when count == WIDTH-1 (last bit), go to DONE; diff and borrow_out take their final values on this edge.
  - DONE: done=1 for exactly one cycle, busy=0. If start=1 in this cycle, accept a new operation exactly as in IDLE (go to RUN). Otherwise go to IDLE.
- Latency: start accepted at edge E0. RUN covers edges E1..EWIDTH. done is high in the cycle after EWIDTH, i.e. WIDTH+1 cycles after E0. Minimum repeat period is WIDTH+1 cycles.
- Output hold: diff and borrow_out stay stable from the done cycle until the next accepted start. On that start, diff and borrow_out clear to 0.
- start while in RUN is ignored. It has no effect on operands or timing.
- a and b are sampled only on the accepted start edge. Changes during RUN have no effect.
- Width rule: diff is modulo 2^WIDTH. borrow_out is the final borrow after the MSB.
- Reset mid-operation: asserting reset at any time immediately returns all state to reset values. There is no done pulse for the aborted operation.
- start held high continuously: operations chain IDLE→RUN→DONE→RUN… with the same captured-at-start semantics.

Decomposition:
- Shared package (arith_pkg): FSM state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2, plus the default WIDTH constant.
- Counter width is $clog2(WIDTH), computed locally.
- One natural sub-module: full_subtractor (a, b, bin → d, bout), purely combinational. It is instantiated once for the serial bit slice and is reusable elsewhere in the lab set.

Test Plan:
- Reset, then a=5, b=3, start one cycle → done after 9 cycles; diff=8'd2, borrow_out=0; busy high exactly 8 cycles.
- a=3, b=5 → diff=8'd254, borrow_out=1. Then a=0, b=1 → diff=8'd255, borrow_out=1.
- Edge values: a=255, b=255 → diff=0, borrow_out=0. a=0, b=0 → diff=0, borrow_out=0. a=128, b=1 → diff=127, borrow_out=0.
- start pulsed mid-RUN with different a/b → ignored; result matches the original operands; only one done pulse.
- start held high across the DONE cycle with new a=10, b=4 → second op accepted without an IDLE cycle; second done exactly 9 cycles after the first; diff=6.
- reset asserted asynchronously (between clock edges) at bit 4 of a=200, b=100 → outputs 0 immediately; no done. A subsequent op with a=200, b=100 → diff=100, borrow_out=0.
